// File: rtl/sha1_pkg.sv
// sha1_pkg: state encoding, message size limit and byte-lane mapping
// shared by the message loader and the SHA-1 hash engine.
package sha1_pkg;
    localparam int SHA1_MAX_BYTES = 511;
    localparam int SHA1_LANE_BITS = 8;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FILL    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_RB_ADDR = 3'd3;
    localparam logic [2:0] ST_RB_WAIT = 3'd4;
    localparam logic [2:0] ST_RB_CMP  = 3'd5;
    localparam logic [2:0] ST_START   = 3'd6;
    localparam logic [2:0] ST_WAIT    = 3'd7;
    // Byte k of a word sits at bits [8k+7:8k]; the engine's endian swap restores message order.
    function automatic logic [4:0] sha1_lane_lsb(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction
endpackage

// File: rtl/sha1_byte_packer.sv
// sha1_byte_packer: accumulates stream bytes into little-endian 32-bit words
// and flags the byte that completes a word (lane 3 or last byte).
module sha1_byte_packer import sha1_pkg::*; (
    input  logic        clk,
    input  logic        nreset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic        i_keep,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_end,
    output logic        o_has_data
);
    logic [31:0] r_word;
    logic [1:0]  r_lane;
    logic        r_any;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_word <= 32'd0;
            r_lane <= 2'd0;
            r_any  <= 1'b0;
        end else if (i_clear) begin
            r_word <= 32'd0;
            r_lane <= 2'd0;
            r_any  <= 1'b0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            if (i_keep) begin
                r_word[sha1_lane_lsb(r_lane) +: SHA1_LANE_BITS] <= i_data;
                r_any <= 1'b1;
            end
        end
    end
    assign o_word     = r_word;
    assign o_word_end = r_lane == 2'd3 || i_last;
    assign o_has_data = r_any;
endmodule

// File: rtl/sha1_msg_loader.sv
// sha1_msg_loader: streams a byte message into dpsram as packed words and launches the hash engine.
// Define MSG_READBACK_EN to read back and verify every written word before launch.
module sha1_msg_loader import sha1_pkg::*; #(
    parameter int MAX_BYTES = SHA1_MAX_BYTES
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        load_start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    output logic        port_A_we,
    input  logic [31:0] port_A_data_out,
    output logic [31:0] message_addr,
    output logic [31:0] message_size,
    output logic        start_hash,
    input  logic        hash_done,
    output logic        busy,
    output logic        load_done,
    output logic        overflow,
    output logic        readback_err
);
`ifdef MSG_READBACK_EN
    localparam logic [2:0] ST_AFTER = ST_RB_ADDR;
`else
    localparam logic [2:0] ST_AFTER = ST_START;
`endif
    logic [2:0]  r_state;
    logic [31:0] r_base;
    logic [31:0] r_size;
    logic [13:0] r_widx;
    logic        r_last;
    logic        r_overflow;
    logic        r_load_done;
    logic        w_accept;
    logic        w_keep;
    logic        w_clear;
    logic        w_word_end;
    logic        w_has_data;
    logic [31:0] w_word;
    logic        w_rb_bad;

    assign w_accept = in_valid && r_state == ST_FILL;
    assign w_keep   = r_size < 32'(MAX_BYTES);
    assign w_clear  = (r_state == ST_IDLE && load_start) || r_state == ST_WRITE;

    sha1_byte_packer u_packer (
        .clk        (clk),
        .nreset     (nreset),
        .i_clear    (w_clear),
        .i_accept   (w_accept),
        .i_keep     (w_keep),
        .i_data     (in_data),
        .i_last     (in_last),
        .o_word     (w_word),
        .o_word_end (w_word_end),
        .o_has_data (w_has_data)
    );

    assign port_A_clk     = clk;
    assign port_A_we      = r_state == ST_WRITE;
    assign port_A_data_in = port_A_we ? w_word : 32'd0;
    assign in_ready       = r_state == ST_FILL;
    assign busy           = r_state != ST_IDLE;
    assign start_hash     = r_state == ST_START;
    assign load_done      = r_load_done;
    assign overflow       = r_overflow;
    assign message_addr   = r_base;
    assign message_size   = r_size;

`ifdef MSG_READBACK_EN
    localparam int DEPTH = (MAX_BYTES + 3) / 4;
    localparam int AW    = $clog2(DEPTH);
    logic [31:0] r_shadow [DEPTH];
    logic [13:0] r_ridx;
    logic        r_rb_err;
    logic        w_rb_phase;
    assign w_rb_phase   = r_state == ST_RB_ADDR || r_state == ST_RB_WAIT || r_state == ST_RB_CMP;
    assign port_A_addr  = r_base[15:0] + {w_rb_phase ? r_ridx : r_widx, 2'b00};
    assign w_rb_bad     = port_A_data_out != r_shadow[r_ridx[AW-1:0]];
    assign readback_err = r_rb_err;
    always_ff @(posedge clk)
        if (port_A_we) r_shadow[r_widx[AW-1:0]] <= w_word;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ridx   <= 14'd0;
            r_rb_err <= 1'b0;
        end else if (r_state == ST_IDLE && load_start) begin
            r_ridx   <= 14'd0;
            r_rb_err <= 1'b0;
        end else if (r_state == ST_RB_CMP) begin
            if (w_rb_bad) r_rb_err <= 1'b1;
            else r_ridx <= r_ridx + 14'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused     = ^port_A_data_out;
    assign w_rb_bad     = 1'b0;
    assign port_A_addr  = r_base[15:0] + {r_widx, 2'b00};
    assign readback_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_base      <= 32'd0;
            r_size      <= 32'd0;
            r_widx      <= 14'd0;
            r_last      <= 1'b0;
            r_overflow  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (load_start) begin
                    r_base     <= base_addr;
                    r_size     <= 32'd0;
                    r_widx     <= 14'd0;
                    r_last     <= 1'b0;
                    r_overflow <= 1'b0;
                    r_state    <= ST_FILL;
                end
                ST_FILL: if (w_accept) begin
                    if (w_keep) r_size <= r_size + 32'd1;
                    else r_overflow <= 1'b1;
                    // A word holding only discarded bytes is never written.
                    if (w_word_end && (w_has_data || w_keep)) begin
                        r_last  <= in_last;
                        r_state <= ST_WRITE;
                    end else if (in_last) r_state <= ST_AFTER;
                end
                ST_WRITE: begin
                    r_widx  <= r_widx + 14'd1;
                    r_state <= r_last ? ST_AFTER : ST_FILL;
                end
`ifdef MSG_READBACK_EN
                ST_RB_ADDR: r_state <= ST_RB_WAIT;
                ST_RB_WAIT: r_state <= ST_RB_CMP;
                ST_RB_CMP: if (w_rb_bad) begin
                    r_load_done <= 1'b1;
                    r_state     <= ST_IDLE;
                end else r_state <= (r_ridx + 14'd1 == r_widx) ? ST_START : ST_RB_ADDR;
`endif
                ST_START: r_state <= ST_WAIT;
                ST_WAIT: if (hash_done) begin
                    r_load_done <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_msg_loader.sv
// tb_sha1_msg_loader: directed message vectors against a dpsram model, plus reset and readback sequences.
module tb_sha1_msg_loader;
    logic        clk = 0, nreset = 0, load_start = 0, in_valid = 0, in_last = 0, hash_done = 0;
    logic [31:0] base_addr = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, port_A_clk, port_A_we, start_hash, busy, load_done, overflow, readback_err;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in, port_A_data_out, message_addr, message_size;

    always #5 clk = ~clk;

    sha1_msg_loader dut (
        .clk(clk), .nreset(nreset), .load_start(load_start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_data_in(port_A_data_in),
        .port_A_we(port_A_we), .port_A_data_out(port_A_data_out),
        .message_addr(message_addr), .message_size(message_size), .start_hash(start_hash),
        .hash_done(hash_done), .busy(busy), .load_done(load_done), .overflow(overflow),
        .readback_err(readback_err)
    );

    logic [31:0] mem [16384];
    logic        corrupt = 0;
    logic [13:0] bad_idx = 0;
    always @(posedge clk) begin
        if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[15:2]] ^ ((corrupt && port_A_addr[15:2] == bad_idx) ? 32'h0000_0100 : 32'h0);
    end

    int n_we = 0, n_start = 0, n_done = 0;
    logic [15:0] last_addr = 0;
    logic [31:0] last_data = 0;
    always @(negedge clk) begin
        if (port_A_we) begin
            n_we      <= n_we + 1;
            last_addr <= port_A_addr;
            last_data <= port_A_data_in;
        end
        if (start_hash) n_start <= n_start + 1;
        if (load_done) n_done <= n_done + 1;
    end

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int          len;
        logic [7:0]  b0;
        bit          poke;
        logic [31:0] size;
        int          writes;
        logic        ovf;
        logic [15:0] first_addr;
        logic [31:0] first_data;
        logic [15:0] last_addr;
        logic [31:0] last_data;
    } vec_t;
    vec_t vecs [7];

    task automatic send_msg(input logic [31:0] base, input int len, input logic [7:0] b0, input bit poke);
        int i, guard;
        logic rdy;
        @(negedge clk);
        base_addr = base; load_start = 1;
        @(negedge clk);
        load_start = 0; base_addr = 32'hDEAD_0000;
        i = 0; guard = 0;
        while (i < len && guard < 2000) begin
            in_valid = 1; in_data = b0 + 8'(i); in_last = (i == len - 1);
            load_start = poke && i == 1;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) i++;
            guard++;
            @(negedge clk);
        end
        in_valid = 0; in_last = 0; load_start = 0;
        chk("bytes_accepted", 32'(i), 32'(len));
    endtask

    task automatic run_vec(input vec_t v);
        int w0, s0, d0, guard;
        w0 = n_we; s0 = n_start; d0 = n_done;
        send_msg(v.base, v.len, v.b0, v.poke);
        guard = 0;
        while (n_start == s0 && guard < 1000) begin @(posedge clk); guard++; end
        @(negedge clk);
        chk("start_pulses", 32'(n_start - s0), 32'd1);
        chk("message_size", message_size, v.size);
        chk("message_addr", message_addr, v.base);
        chk("overflow", {31'd0, overflow}, {31'd0, v.ovf});
        chk("readback_err", {31'd0, readback_err}, 32'd0);
        chk("busy_in_wait", {31'd0, busy}, 32'd1);
        hash_done = 1;
        @(negedge clk);
        hash_done = 0;
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(n_done - d0), 32'd1);
        chk("write_count", 32'(n_we - w0), 32'(v.writes));
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("last_addr", {16'd0, last_addr}, {16'd0, v.last_addr});
        chk("last_data", last_data, v.last_data);
        chk("first_word", mem[v.first_addr[15:2]], v.first_data);
        chk("size_stable", message_size, v.size);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int w0, s0, d0, guard;
        vecs[0] = '{32'h0000_0100,   3, 8'h61, 0, 32'd3,   1,   1'b0, 16'h0100, 32'h0063_6261, 16'h0100, 32'h0063_6261};
        vecs[1] = '{32'h0000_0200,   8, 8'h00, 1, 32'd8,   2,   1'b0, 16'h0200, 32'h0302_0100, 16'h0204, 32'h0706_0504};
        vecs[2] = '{32'h0000_0040,   1, 8'hA5, 0, 32'd1,   1,   1'b0, 16'h0040, 32'h0000_00A5, 16'h0040, 32'h0000_00A5};
        vecs[3] = '{32'h0000_0300, 520, 8'h00, 0, 32'd511, 128, 1'b1, 16'h0300, 32'h0302_0100, 16'h04FC, 32'h00FE_FDFC};
        vecs[4] = '{32'h1234_FFF8,  13, 8'h10, 0, 32'd13,  4,   1'b0, 16'hFFF8, 32'h1312_1110, 16'h0004, 32'h0000_001C};
        vecs[5] = '{32'h0000_0000, 511, 8'h00, 0, 32'd511, 128, 1'b0, 16'h0000, 32'h0302_0100, 16'h01FC, 32'h00FE_FDFC};
        vecs[6] = '{32'h0000_0800, 512, 8'h00, 0, 32'd511, 128, 1'b1, 16'h0800, 32'h0302_0100, 16'h09FC, 32'h00FE_FDFC};

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, port_A_we}, 32'd0);
        chk("rst_start", {31'd0, start_hash}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_rb_err", {31'd0, readback_err}, 32'd0);
        chk("rst_size", message_size, 32'd0);
        chk("rst_addr", message_addr, 32'd0);
        chk("rst_port_addr", {16'd0, port_A_addr}, 32'd0);
        chk("rst_port_data", port_A_data_in, 32'd0);
        chk("port_clk", {31'd0, port_A_clk}, {31'd0, clk});
        nreset = 1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        w0 = n_we; s0 = n_start;
        @(negedge clk);
        base_addr = 32'h500; load_start = 1;
        @(negedge clk);
        load_start = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_data = 8'(k); in_last = 0;
            @(negedge clk);
        end
        chk("mid_size_2", message_size, 32'd2);
        in_data = 8'h02;
        nreset = 0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_size", message_size, 32'd0);
        chk("mid_rst_addr", message_addr, 32'd0);
        repeat (4) @(negedge clk);
        nreset = 1;
        repeat (6) @(negedge clk);
        in_valid = 0;
        chk("mid_no_we", 32'(n_we - w0), 32'd0);
        chk("mid_no_start", 32'(n_start - s0), 32'd0);
        chk("mid_idle", {31'd0, busy}, 32'd0);
        run_vec(vecs[0]);

`ifdef MSG_READBACK_EN
        w0 = n_we; s0 = n_start; d0 = n_done;
        corrupt = 1; bad_idx = 14'h1C1;
        send_msg(32'h0000_0700, 8, 8'h00, 0);
        guard = 0;
        while (n_done == d0 && guard < 200) begin @(posedge clk); guard++; end
        @(negedge clk);
        chk("rb_err_set", {31'd0, readback_err}, 32'd1);
        chk("rb_no_start", 32'(n_start - s0), 32'd0);
        chk("rb_done_pulse", 32'(n_done - d0), 32'd1);
        chk("rb_writes", 32'(n_we - w0), 32'd2);
        chk("rb_idle", {31'd0, busy}, 32'd0);
        corrupt = 0;
        run_vec(vecs[1]);
`else
        w0 = 0; s0 = 0; d0 = 0; guard = 0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
